laser_scan_sched: RTL and testbench

Scan scheduler for the laser-coverage datapath. It sweeps one candidate circle centre across the full 16x16 grid in raster order. For each candidate it steps the 40-point buffer through 10 batches of 4 points and accumulates the per-batch hit count returned by the coverage evaluators. It keeps the best candidate and reports it with a one-cycle done pulse. An outer iteration controller invokes it once per FIRST_TRY / FIND_C1 / FIND_C2 pass.

---
 rtl/laser_scan_sched.sv | 155 +++++++++++++++
 tb/tb_laser_scan_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_scan_sched.sv
// Scan scheduler: sweeps a candidate centre over the 16x16 grid, accumulates
// per-batch evaluator hits over 10 batches and keeps the best candidate.
module laser_scan_sched #(
  parameter int unsigned GRID    = 16,
  parameter int unsigned BATCHES = 10,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       fix_x,
  input  logic [3:0]       fix_y,
  input  logic [2:0]       hit_cnt,
  output logic [3:0]       c1x,
  output logic [3:0]       c1y,
  output logic [3:0]       c2x,
  output logic [3:0]       c2y,
  output logic [3:0]       batch_idx,
  output logic             shift_en,
  output logic             busy,
  output logic [3:0]       best_x,
  output logic [3:0]       best_y,
  output logic [CNT_W-1:0] best_num,
  output logic             done
);

  localparam int unsigned CW = 4;
  localparam int unsigned HW = 3;

  localparam logic [1:0] MODE_FIRST = 2'd0;
  localparam logic [1:0] MODE_C1    = 2'd1;
  localparam logic [1:0] MODE_C2    = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_q;
  logic [CW-1:0]    fix_x_q, fix_y_q;
  logic [CW-1:0]    cand_x, cand_y;
  logic [CNT_W-1:0] acc;

  logic             last_batch, last_cand, start_ok;
  logic [HW-1:0]    hit_eff;
  logic [CNT_W-1:0] total;

  assign last_batch = (batch_idx == CW'(BATCHES - 1));
  assign last_cand  = (cand_x == CW'(GRID - 1)) && (cand_y == CW'(GRID - 1));
  assign start_ok   = start && (mode != MODE_RSVD);
  // Evaluators can report up to 7; a batch never holds more than LANES hits.
  assign hit_eff    = (hit_cnt > HW'(LANES)) ? HW'(LANES) : hit_cnt;
  assign total      = acc + CNT_W'(hit_eff);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus centre/shift decode (state and registers only).
  always_comb begin
    state_nxt = state;
    c1x       = '0;
    c1y       = '0;
    c2x       = '0;
    c2y       = '0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = SCAN;
      end
      SCAN: begin
        shift_en = 1'b1;
        case (mode_q)
          MODE_C1: begin
            c1x = cand_x;  c1y = cand_y;
            c2x = fix_x_q; c2y = fix_y_q;
          end
          MODE_C2: begin
            c1x = fix_x_q; c1y = fix_y_q;
            c2x = cand_x;  c2y = cand_y;
          end
          default: begin
            c1x = cand_x;  c1y = cand_y;
            c2x = cand_x;  c2y = cand_y;
          end
        endcase
        if (last_batch && last_cand) state_nxt = REPORT;
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, accumulator, best tracking and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q    <= MODE_FIRST;
      fix_x_q   <= '0;
      fix_y_q   <= '0;
      cand_x    <= '0;
      cand_y    <= '0;
      batch_idx <= '0;
      acc       <= '0;
      best_x    <= '0;
      best_y    <= '0;
      best_num  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == REPORT);
      case (state)
        IDLE: begin
          if (start_ok) begin
            mode_q    <= mode;
            fix_x_q   <= fix_x;
            fix_y_q   <= fix_y;
            cand_x    <= '0;
            cand_y    <= '0;
            batch_idx <= '0;
            acc       <= '0;
            best_num  <= '0;
          end
        end
        SCAN: begin
          if (!last_batch) begin
            acc       <= total;
            batch_idx <= batch_idx + CW'(1);
          end else begin
            // >= lets the later raster candidate win ties.
            if (total >= best_num) begin
              best_x   <= cand_x;
              best_y   <= cand_y;
              best_num <= total;
            end
            acc       <= '0;
            batch_idx <= '0;
            if (cand_x == CW'(GRID - 1)) begin
              cand_x <= '0;
              cand_y <= cand_y + CW'(1);
            end else begin
              cand_x <= cand_x + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  wire unused_mode = (mode_q == MODE_C2);

endmodule

// File: tb/tb_laser_scan_sched.sv
// Self-checking bench for laser_scan_sched: per-candidate hit tables drive the
// evaluator input and a raster-order reference picks the expected best centre.
module tb_laser_scan_sched;

  logic       CLK, RST, start;
  logic [1:0] mode;
  logic [3:0] fix_x, fix_y;
  logic [2:0] hit_cnt;
  logic [3:0] c1x, c1y, c2x, c2y, batch_idx, best_x, best_y;
  logic       shift_en, busy, done;
  logic [5:0] best_num;

  int total, bad;
  int tab [256][10];
  int exp_x, exp_y, exp_n;

  laser_scan_sched dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .fix_x(fix_x), .fix_y(fix_y),
    .hit_cnt(hit_cnt), .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
    .batch_idx(batch_idx), .shift_en(shift_en), .busy(busy),
    .best_x(best_x), .best_y(best_y), .best_num(best_num), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic fill_const(input int v);
    for (int c = 0; c < 256; c++)
      for (int b = 0; b < 10; b++) tab[c][b] = v;
  endtask

  // Reference: sum clamped hits per candidate, last best-or-equal in raster order wins.
  task automatic model_best();
    int t;
    exp_x = 0; exp_y = 0; exp_n = 0;
    for (int c = 0; c < 256; c++) begin
      t = 0;
      for (int b = 0; b < 10; b++) t += (tab[c][b] > 4) ? 4 : tab[c][b];
      if (t >= exp_n) begin
        exp_n = t; exp_x = c % 16; exp_y = c / 16;
      end
    end
  endtask

  // Runs one full pass from IDLE, checking every SCAN cycle and the done cycle.
  task automatic run_pass(input int m, input int fx, input int fy, input bit pulse);
    int cand, b, cx, cy, e1x, e1y, e2x, e2y;
    model_best();
    @(negedge CLK);
    start = 1'b1; mode = 2'(m); fix_x = 4'(fx); fix_y = 4'(fy); hit_cnt = '0;
    @(negedge CLK);
    mode = 2'($urandom); fix_x = 4'($urandom); fix_y = 4'($urandom);
    for (int i = 0; i < 2560; i++) begin
      cand = i / 10; b = i % 10; cx = cand % 16; cy = cand / 16;
      start   = pulse && (i == 700);
      hit_cnt = 3'(tab[cand][b]);
      e1x = cx; e1y = cy; e2x = cx; e2y = cy;
      if (m == 1) begin e2x = fx; e2y = fy; end
      if (m == 2) begin e1x = fx; e1y = fy; end
      total++;
      if ({c1x, c1y, c2x, c2y} !== {4'(e1x), 4'(e1y), 4'(e2x), 4'(e2y)}) begin
        bad++;
        $display("FAIL scan_centres cyc=%0d got=%h need=%h", i, {c1x, c1y, c2x, c2y},
                 {4'(e1x), 4'(e1y), 4'(e2x), 4'(e2y)});
      end
      total++;
      if (batch_idx !== 4'(b)) begin
        bad++;
        $display("FAIL scan_batch cyc=%0d got=%0d need=%0d", i, batch_idx, b);
      end
      total++;
      if ({shift_en, busy, done} !== 3'b110) begin
        bad++;
        $display("FAIL scan_flags cyc=%0d got=%b need=110", i, {shift_en, busy, done});
      end
      @(negedge CLK);
    end
    start = pulse;
    hit_cnt = 3'($urandom);
    total++;
    if ({done, busy, shift_en, c1x, c1y, c2x, c2y} !== {1'b1, 1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL report_cycle got=%h need=%h", {done, busy, shift_en, c1x, c1y, c2x, c2y},
               {1'b1, 1'b1, 1'b0, 16'h0});
    end
    total++;
    if ({best_x, best_y, best_num} !== {4'(exp_x), 4'(exp_y), 6'(exp_n)}) begin
      bad++;
      $display("FAIL report_best got=(%0d,%0d,%0d) need=(%0d,%0d,%0d)",
               best_x, best_y, best_num, exp_x, exp_y, exp_n);
    end
    @(negedge CLK);
    start = 1'b0;
    total++;
    if ({done, busy, best_x, best_y, best_num} !== {2'b00, 4'(exp_x), 4'(exp_y), 6'(exp_n)}) begin
      bad++;
      $display("FAIL post_pass got=%h need=%h", {done, busy, best_x, best_y, best_num},
               {2'b00, 4'(exp_x), 4'(exp_y), 6'(exp_n)});
    end
    // Nothing may restart after an ignored start pulse.
    repeat (3) begin
      @(negedge CLK);
      total++;
      if ({done, busy} !== 2'b00) begin
        bad++;
        $display("FAIL idle_quiet got=%b need=00", {done, busy});
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++;
    if ({busy, done, shift_en, c1x, c1y, c2x, c2y, batch_idx, best_x, best_y, best_num} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h need=0",
               {busy, done, shift_en, c1x, c1y, c2x, c2y, batch_idx, best_x, best_y, best_num});
    end
    RST = 1'b0;
  endtask

  task automatic test_first_try_full();
    fill_const(4);
    run_pass(0, 0, 0, 1'b0);
    total++;
    if ({best_x, best_y, best_num} !== {4'd15, 4'd15, 6'd40}) begin
      bad++;
      $display("FAIL first_try_full got=(%0d,%0d,%0d) need=(15,15,40)", best_x, best_y, best_num);
    end
  endtask

  task automatic test_find_c1();
    fill_const(1);
    for (int b = 0; b < 10; b++) tab[9 * 16 + 5][b] = 4;
    run_pass(1, 2, 3, 1'b0);
    total++;
    if ({best_x, best_y, best_num} !== {4'd5, 4'd9, 6'd40}) begin
      bad++;
      $display("FAIL find_c1 got=(%0d,%0d,%0d) need=(5,9,40)", best_x, best_y, best_num);
    end
  endtask

  task automatic test_find_c2_tie_and_ignored_start();
    fill_const(0);
    for (int b = 0; b < 10; b++) begin
      tab[0][b] = 3;
      tab[4 * 16 + 12][b] = 3;
    end
    run_pass(2, 7, 7, 1'b1);
    total++;
    if ({best_x, best_y, best_num} !== {4'd12, 4'd4, 6'd30}) begin
      bad++;
      $display("FAIL find_c2_tie got=(%0d,%0d,%0d) need=(12,4,30)", best_x, best_y, best_num);
    end
  endtask

  task automatic test_mode3_ignored();
    @(negedge CLK);
    start = 1'b1; mode = 2'd3;
    repeat (5) begin
      @(negedge CLK);
      total++;
      if ({busy, done, shift_en, best_x, best_y, best_num} !== {3'b000, 4'd12, 4'd4, 6'd30}) begin
        bad++;
        $display("FAIL mode3_ignored got=%h need=%h", {busy, done, shift_en, best_x, best_y, best_num},
                 {3'b000, 4'd12, 4'd4, 6'd30});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    fill_const(4);
    @(negedge CLK);
    start = 1'b1; mode = 2'd0; hit_cnt = 3'd4;
    @(negedge CLK);
    start = 1'b0;
    repeat (999) @(negedge CLK);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pass_busy got=%b need=1", busy);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({busy, done, shift_en, c1x, c1y, c2x, c2y, batch_idx, best_x, best_y, best_num} !== '0) begin
      bad++;
      $display("FAIL mid_pass_reset got=%h need=0",
               {busy, done, shift_en, c1x, c1y, c2x, c2y, batch_idx, best_x, best_y, best_num});
    end
    run_pass(0, 0, 0, 1'b0);
  endtask

  task automatic test_clamp();
    fill_const(7);
    run_pass(0, 0, 0, 1'b0);
    total++;
    if ({best_x, best_y, best_num} !== {4'd15, 4'd15, 6'd40}) begin
      bad++;
      $display("FAIL clamp got=(%0d,%0d,%0d) need=(15,15,40)", best_x, best_y, best_num);
    end
  endtask

  task automatic test_random(input int passes);
    int hi;
    for (int p = 0; p < passes; p++) begin
      hi = (p == 0) ? 1 : 7;
      for (int c = 0; c < 256; c++)
        for (int b = 0; b < 10; b++) tab[c][b] = int'($urandom_range(0, hi));
      run_pass(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), 1'($urandom));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    RST = 1'b1; start = 1'b0; mode = '0; fix_x = '0; fix_y = '0; hit_cnt = '0;
    test_reset();
    test_first_try_full();
    test_find_c1();
    test_find_c2_tie_and_ignored_start();
    test_mode3_ignored();
    test_reset_mid_pass();
    test_clamp();
    test_random(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
